ifetch_stage: RTL and testbench

Instruction-fetch stage sitting directly upstream of the instruction cache. It owns the program counter and issues one word read at a time on the ifetch/icache handshake. Returned instructions, tagged with their PC, go into a 2-entry queue that feeds decode through a valid/ready interface. Redirects from execute squash in-flight and queued fetches.

---
 rtl/ifetch_stage.sv | 143 ++++++++++++++
 tb/tb_ifetch_stage.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_stage.sv
// Instruction-fetch stage: owns the PC, issues one icache word read at a time,
// and buffers returned {instr, pc} pairs in a 2-entry queue feeding decode.
module ifetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_ifetch_redirect,
  input  logic [31:0] ex_ifetch_target,
  output logic [31:0] ifetch_icache_addr,
  output logic        ifetch_icache_read,
  input  logic [31:0] icache_ifetch_rdata,
  input  logic        icache_ifetch_resp,
  output logic [31:0] ifetch_decode_instr,
  output logic [31:0] ifetch_decode_pc,
  output logic        ifetch_decode_valid,
  input  logic        decode_ifetch_ready
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    SQUASH = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] pc;
  logic [31:0] req_addr;
  logic [31:0] redirect_pc;

  logic [31:0] fifo_instr [2];
  logic [31:0] fifo_pc    [2];
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  count;
  logic [1:0]  count_post;

  logic        pop;
  logic        push;
  logic        launch;
  logic        launch_ok;

  assign redirect_pc = ex_ifetch_target & ~32'h0000_0003;

  // Redirect flushes the queue, so a pop in that cycle is meaningless.
  assign pop        = (count != 2'd0) && decode_ifetch_ready && !ex_ifetch_redirect;
  assign push       = (state == BUSY) && icache_ifetch_resp && !ex_ifetch_redirect;
  assign count_post = count + {1'b0, push} - {1'b0, pop};
  // Launching only when the queue will hold at most one entry reserves room
  // for the response, so a push never meets a full queue.
  assign launch_ok  = (count_post <= 2'd1);

  always_comb begin
    state_next = state;
    launch     = 1'b0;
    case (state)
      IDLE: begin
        if (!ex_ifetch_redirect && launch_ok) begin
          launch = 1'b1;
        end
      end
      BUSY: begin
        if (icache_ifetch_resp) begin
          if (ex_ifetch_redirect) begin
            state_next = IDLE;
          end else if (launch_ok) begin
            launch = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end else if (ex_ifetch_redirect) begin
          state_next = SQUASH;
        end
      end
      SQUASH: begin
        if (icache_ifetch_resp) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (launch) begin
      state_next = BUSY;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      req_addr <= 32'h0;
    end else begin
      state <= state_next;
      if (ex_ifetch_redirect) begin
        pc <= redirect_pc;
      end else if (launch) begin
        req_addr <= pc;
        pc       <= pc + 32'd4;
      end
    end
  end

  // Pointers return to zero on a flush so the head and tail stay aligned.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (ex_ifetch_redirect) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count_post;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fifo_instr[0] <= 32'h0;
      fifo_instr[1] <= 32'h0;
      fifo_pc[0]    <= 32'h0;
      fifo_pc[1]    <= 32'h0;
    end else if (push) begin
      fifo_instr[wr_ptr] <= icache_ifetch_rdata;
      fifo_pc[wr_ptr]    <= req_addr;
    end
  end

  assign ifetch_icache_addr  = req_addr;
  assign ifetch_icache_read  = (state != IDLE);
  assign ifetch_decode_instr = fifo_instr[rd_ptr];
  assign ifetch_decode_pc    = fifo_pc[rd_ptr];
  assign ifetch_decode_valid = (count != 2'd0);

endmodule

// File: tb/tb_ifetch_stage.sv
// Randomized bench for ifetch_stage: an icache/decode stimulus driver plus a
// queue-based reference model of the fetch rules, checked every cycle.
module tb_ifetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ex_ifetch_redirect = 1'b0;
  logic [31:0] ex_ifetch_target = 32'h0;
  logic [31:0] ifetch_icache_addr;
  logic        ifetch_icache_read;
  logic [31:0] icache_ifetch_rdata = 32'h0;
  logic        icache_ifetch_resp = 1'b0;
  logic [31:0] ifetch_decode_instr;
  logic [31:0] ifetch_decode_pc;
  logic        ifetch_decode_valid;
  logic        decode_ifetch_ready = 1'b0;

  always #5 clk = ~clk;

  ifetch_stage #(.RESET_PC(RST_PC)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .ex_ifetch_redirect  (ex_ifetch_redirect),
    .ex_ifetch_target    (ex_ifetch_target),
    .ifetch_icache_addr  (ifetch_icache_addr),
    .ifetch_icache_read  (ifetch_icache_read),
    .icache_ifetch_rdata (icache_ifetch_rdata),
    .icache_ifetch_resp  (icache_ifetch_resp),
    .ifetch_decode_instr (ifetch_decode_instr),
    .ifetch_decode_pc    (ifetch_decode_pc),
    .ifetch_decode_valid (ifetch_decode_valid),
    .decode_ifetch_ready (decode_ifetch_ready)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  // Reference model: queued instructions, next fetch PC, outstanding request.
  entry_t      mq[$];
  logic [31:0] m_pc;
  logic [31:0] m_addr;
  bit          m_pend;
  bit          m_live;
  int          m_wait;
  int          m_delay;

  // Stimulus knobs.
  int          ready_mode;
  int          base_delay;
  bit          rand_delay;
  logic [31:0] slow_addr;
  int          slow_delay;
  int          redir_prob;
  bit          force_redir;
  bit          redir_on_resp;
  logic [31:0] arm_addr;
  int          arm_wait;
  logic [31:0] arm_target;

  int check_count = 0;
  int pass_count  = 0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got %h expected %h at %0t", tag, actual, expected, $time);
  endtask

  task automatic modelReset();
    mq.delete();
    m_pc    = RST_PC;
    m_addr  = 32'h0;
    m_pend  = 1'b0;
    m_live  = 1'b0;
    m_wait  = 0;
    m_delay = 0;
  endtask

  task automatic checkResetOutputs();
    checkOutput("rst_read",  {31'b0, ifetch_icache_read},  32'h0);
    checkOutput("rst_addr",  ifetch_icache_addr,           32'h0);
    checkOutput("rst_valid", {31'b0, ifetch_decode_valid}, 32'h0);
    checkOutput("rst_instr", ifetch_decode_instr,          32'h0);
    checkOutput("rst_pc",    ifetch_decode_pc,             32'h0);
  endtask

  task automatic cycleCheck();
    checkOutput("read", {31'b0, ifetch_icache_read}, {31'b0, m_pend});
    if (m_pend) checkOutput("addr", ifetch_icache_addr, m_addr);
    checkOutput("valid", {31'b0, ifetch_decode_valid}, {31'b0, mq.size() != 0});
    if (mq.size() != 0) begin
      checkOutput("head_instr", ifetch_decode_instr, mq[0].instr);
      checkOutput("head_pc",    ifetch_decode_pc,    mq[0].pc);
    end
  endtask

  task automatic applyStimulus();
    int d;
    logic rdy;
    logic rsp;
    logic rdr;
    logic [31:0] tgt;
    case (ready_mode)
      0:       rdy = 1'b0;
      1:       rdy = 1'b1;
      default: rdy = ($urandom_range(0, 99) < 70);
    endcase
    d   = (m_addr == slow_addr) ? slow_delay : m_delay;
    rsp = m_pend && (m_wait >= d);
    rdr = 1'b0;
    tgt = $urandom();
    if (redir_prob > 0 && $urandom_range(0, 99) < redir_prob) rdr = 1'b1;
    if (force_redir) begin
      rdr = 1'b1;
      tgt = arm_target;
      force_redir = 1'b0;
    end else if (m_pend && m_addr == arm_addr && m_wait == arm_wait) begin
      rdr = 1'b1;
      tgt = arm_target;
      arm_addr = 32'hFFFF_FFFF;
    end else if (redir_on_resp && rsp && mq.size() >= 1) begin
      rdr = 1'b1;
      tgt = arm_target;
      redir_on_resp = 1'b0;
    end
    decode_ifetch_ready = rdy;
    icache_ifetch_resp  = rsp;
    icache_ifetch_rdata = rsp ? (m_addr ^ 32'hA5A5_0000) : $urandom();
    ex_ifetch_redirect  = rdr;
    ex_ifetch_target    = tgt;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic modelStep();
    bit free_slot;
    if (ex_ifetch_redirect) begin
      mq.delete();
      if (m_pend && icache_ifetch_resp) m_pend = 1'b0;
      else if (m_pend) begin
        m_live = 1'b0;
        m_wait++;
      end
      m_pc = ex_ifetch_target & ~32'h3;
    end else begin
      free_slot = !m_pend;
      if (mq.size() > 0 && decode_ifetch_ready) void'(mq.pop_front());
      if (m_pend) begin
        if (icache_ifetch_resp) begin
          if (m_live) begin
            mq.push_back('{instr: icache_ifetch_rdata, pc: m_addr});
            free_slot = 1'b1;
          end
          m_pend = 1'b0;
        end else begin
          m_wait++;
        end
      end
      if (free_slot && mq.size() <= 1) begin
        m_addr  = m_pc;
        m_pc    = m_pc + 32'd4;
        m_pend  = 1'b1;
        m_live  = 1'b1;
        m_wait  = 0;
        m_delay = rand_delay ? int'($urandom_range(0, 3)) : base_delay;
      end
    end
  endtask

  task automatic runCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cycleCheck();
      applyStimulus();
      if (rst) modelStep();
    end
  endtask

  task automatic releaseReset(input bit stray_resp);
    @(posedge clk);
    #1;
    cycleCheck();
    rst = 1'b1;
    applyStimulus();
    if (stray_resp) icache_ifetch_resp = 1'b1;
    modelStep();
  endtask

  initial begin
    int guard;
    ready_mode    = 1;
    base_delay    = 0;
    rand_delay    = 1'b0;
    slow_addr     = 32'hFFFF_FFFF;
    slow_delay    = 0;
    redir_prob    = 0;
    force_redir   = 1'b0;
    redir_on_resp = 1'b0;
    arm_addr      = 32'hFFFF_FFFF;
    arm_wait      = 0;
    arm_target    = 32'h0;
    modelReset();

    #2;
    checkResetOutputs();
    runCycles(2);
    releaseReset(1'b0);

    $display("[TB] streaming with single-cycle hits");
    runCycles(12);

    $display("[TB] backpressure");
    ready_mode  = 0;
    force_redir = 1'b1;
    arm_target  = 32'h0000_0100;
    runCycles(10);
    ready_mode  = 1;
    runCycles(6);

    $display("[TB] redirect during a miss");
    force_redir = 1'b1;
    arm_target  = 32'h0000_0100;
    runCycles(1);
    slow_addr  = 32'h0000_0104;
    slow_delay = 5;
    arm_addr   = 32'h0000_0104;
    arm_wait   = 2;
    arm_target = 32'h0000_0203;
    runCycles(20);
    slow_addr  = 32'hFFFF_FFFF;

    $display("[TB] redirect coincident with a response");
    ready_mode  = 0;
    base_delay  = 1;
    force_redir = 1'b1;
    arm_target  = 32'h0000_0300;
    runCycles(1);
    redir_on_resp = 1'b1;
    arm_target    = 32'h0000_0400;
    runCycles(10);
    ready_mode = 1;
    runCycles(6);

    $display("[TB] asynchronous reset while busy");
    base_delay = 3;
    guard = 0;
    while (!m_pend && guard < 20) begin
      runCycles(1);
      guard++;
    end
    #3;
    rst = 1'b0;
    #1;
    checkResetOutputs();
    modelReset();
    ex_ifetch_redirect = 1'b0;
    icache_ifetch_resp = 1'b1;
    runCycles(2);
    releaseReset(1'b1);
    runCycles(8);

    $display("[TB] randomized traffic");
    ready_mode = 2;
    rand_delay = 1'b1;
    redir_prob = 6;
    runCycles(400);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
